// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2/stride-2 signed max pool over raster-order conv pixels.
// Define MAXPOOL_SAT8_EN to clamp each pooled result to 0..255.
module maxpool2x2_stream #(
   parameter int WIDTH   = 32,
   parameter int HEIGHT  = 32,
   parameter int FILTERS = 16,
   parameter int ADDR_W  = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [31:0]  in_data,
   input  logic                in_valid,
   output logic        [31:0]  pool_data,
   output logic [ADDR_W-1:0]   pool_addr,
   output logic                pool_valid,
   output logic                done
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int FW = (FILTERS > 1) ? $clog2(FILTERS) : 1;
   localparam int LW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t              state_q;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic [FW-1:0]       f_q, f_d;
   logic [ADDR_W-1:0]   addr_q, pa_q;
   logic [31:0]         pd_q;
   logic                pv_q, done_q;
   logic signed [31:0]  h_q, m2_d, m3_d, lb_rd, res_d;
   logic signed [31:0]  lb_q [WIDTH/2];
   logic [LW-1:0]       lb_idx;
   logic                accept, col_last, row_last, last_d;
   assign accept   = (state_q == RUN) && in_valid;
   assign col_last = col_q == CW'(WIDTH - 1);
   assign row_last = row_q == RW'(HEIGHT - 1);
   assign last_d   = col_last && row_last && (f_q == FW'(FILTERS - 1));
   assign col_d    = col_last ? '0 : col_q + CW'(1);
   assign row_d    = col_last ? (row_last ? '0 : row_q + RW'(1)) : row_q;
   assign f_d      = (col_last && row_last) ? f_q + FW'(1) : f_q;
   assign lb_idx   = LW'(col_q >> 1);
   assign lb_rd    = lb_q[lb_idx];
   assign m2_d     = (h_q > in_data) ? h_q : in_data;
   assign m3_d     = (lb_rd > m2_d) ? lb_rd : m2_d;
`ifdef MAXPOOL_SAT8_EN
   assign res_d    = m3_d[31] ? 32'sd0 : (m3_d > 32'sd255) ? 32'sd255 : m3_d;
`else
   assign res_d    = m3_d;
`endif
   // Even rows fold their horizontal pair max into the line buffer for the odd row below.
   always_ff @(posedge clk)
      if (accept && col_q[0] && !row_q[0]) lb_q[lb_idx] <= m2_d;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         f_q     <= '0;
         h_q     <= '0;
         addr_q  <= '0;
         pa_q    <= '0;
         pd_q    <= '0;
         pv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         pv_q <= 1'b0;
         case (state_q)
            IDLE, DONE: if (start) begin
               state_q <= RUN;
               col_q   <= '0;
               row_q   <= '0;
               f_q     <= '0;
               h_q     <= '0;
               addr_q  <= '0;
               done_q  <= 1'b0;
            end
            RUN: if (in_valid) begin
               col_q <= col_d;
               row_q <= row_d;
               f_q   <= f_d;
               if (!col_q[0]) h_q <= in_data;
               else if (row_q[0]) begin
                  pv_q   <= 1'b1;
                  pd_q   <= res_d;
                  pa_q   <= addr_q;
                  addr_q <= addr_q + ADDR_W'(1);
               end
               if (last_d) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign pool_data  = pd_q;
   assign pool_addr  = pa_q;
   assign pool_valid = pv_q;
   assign done       = done_q;
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream: one-filter and sixteen-filter instances fed the same stream,
// checked every cycle against a window-level model plus hand-computed literals.
module tb_maxpool2x2_stream;
   logic clk = 1'b0;
   logic rst, start, in_valid;
   logic [31:0] in_data;
   logic        pv [2];
   logic [31:0] pd [2];
   logic [11:0] pa [2];
   logic        dn [2];
   int n_chk = 0, n_fail = 0;
   bit          run [2];
   int          k [2];
   logic        e_pv [2];
   logic [31:0] e_pd [2];
   logic [11:0] e_pa [2];
   logic        e_dn [2];
   int          pix [2][16384];
   int          mk, mr, mc;
   logic [31:0] sd0 [$];
   logic [11:0] sa0 [$];
   logic        sn0 [$];
   logic [11:0] sa1 [$];
   int          b, b1;
`ifdef MAXPOOL_SAT8_EN
   localparam int SAT_A = 255, SAT_B = 0;
`else
   localparam int SAT_A = 300, SAT_B = -2;
`endif
   always #5 clk = ~clk;
   maxpool2x2_stream #(.WIDTH(32), .HEIGHT(32), .FILTERS(1), .ADDR_W(12)) u_f1 (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .pool_data(pd[0]), .pool_addr(pa[0]), .pool_valid(pv[0]), .done(dn[0]));
   maxpool2x2_stream #(.WIDTH(32), .HEIGHT(32), .FILTERS(16), .ADDR_W(12)) u_f16 (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .pool_data(pd[1]), .pool_addr(pa[1]), .pool_valid(pv[1]), .done(dn[1]));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
      end
   endtask
   function automatic logic [31:0] pool4(input int a, input int b2, input int c, input int d);
      int m;
      m = a;
      if (b2 > m) m = b2;
      if (c > m) m = c;
      if (d > m) m = d;
`ifdef MAXPOOL_SAT8_EN
      if (m < 0) m = 0;
      if (m > 255) m = 255;
`endif
      return 32'(m);
   endfunction
   function automatic int val(input int kind, input int kx);
      int r, c, w, p;
      int s1 [4];
      int s2 [4];
      s1 = '{300, 2, 3, 4};
      s2 = '{-5, -9, -2, -7};
      r = (kx / 32) % 32;
      c = kx % 32;
      w = (r / 2) * 16 + c / 2;
      p = (r % 2) * 2 + c % 2;
      case (kind)
         0: return r * 32 + c;
         1: return (p == w % 4) ? 500 : 7;
         2: begin
            if (r < 2 && c < 2) return s1[r * 2 + c];
            if (r < 2 && c < 4) return s2[r * 2 + c - 2];
            return 0;
         end
         default: return int'($urandom);
      endcase
   endfunction
   task automatic cyc(input logic s, input logic v, input logic [31:0] x);
      start = s; in_valid = v; in_data = x;
      @(posedge clk); #1;
   endtask
   task automatic pixels(input int kind, input int npx, input bit gap);
      for (int i = 0; i < npx; i++) begin
         if (gap || (kind == 3 && $urandom_range(0, 3) == 0)) cyc(1'b0, 1'b0, 32'd0);
         cyc(1'b0, 1'b1, val(kind, i));
      end
   endtask
   task automatic ramp_check(input string tag, input int base);
      chk({tag, "_count"}, sd0.size() - base, 256);
      if (sd0.size() - base == 256) begin
         chk({tag, "_first_data"}, sd0[base], 33);
         chk({tag, "_first_addr"}, sa0[base], 0);
         chk({tag, "_last_data"}, sd0[base + 255], 1023);
         chk({tag, "_last_addr"}, sa0[base + 255], 255);
         chk({tag, "_done_with_last"}, sn0[base + 255], 1);
         chk({tag, "_done_before_last"}, sn0[base + 254], 0);
      end
   endtask
   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      fork
         forever begin
            @(posedge clk or posedge rst);
            for (int d = 0; d < 2; d++) begin
               if (rst) begin
                  run[d] = 0; k[d] = 0; e_pv[d] = 0; e_pd[d] = 0; e_pa[d] = 0; e_dn[d] = 0;
               end else begin
                  e_pv[d] = 0;
                  if (!run[d]) begin
                     if (start) begin run[d] = 1; k[d] = 0; e_dn[d] = 0; end
                  end else if (in_valid) begin
                     mk = k[d];
                     pix[d][mk] = int'(in_data);
                     mr = (mk / 32) % 32;
                     mc = mk % 32;
                     if (mr % 2 == 1 && mc % 2 == 1) begin
                        e_pv[d] = 1;
                        e_pd[d] = pool4(pix[d][mk-33], pix[d][mk-32], pix[d][mk-1], pix[d][mk]);
                        e_pa[d] = 12'((mk / 1024) * 256 + (mr / 2) * 16 + mc / 2);
                     end
                     k[d] = mk + 1;
                     if (k[d] == ((d == 0) ? 1024 : 16384)) begin run[d] = 0; e_dn[d] = 1; end
                  end
               end
            end
         end
         forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
               chk(d == 0 ? "f1_pool_valid" : "f16_pool_valid", pv[d], e_pv[d]);
               chk(d == 0 ? "f1_pool_data" : "f16_pool_data", pd[d], e_pd[d]);
               chk(d == 0 ? "f1_pool_addr" : "f16_pool_addr", pa[d], e_pa[d]);
               chk(d == 0 ? "f1_done" : "f16_done", dn[d], e_dn[d]);
            end
            if (pv[0] === 1'b1) begin sd0.push_back(pd[0]); sa0.push_back(pa[0]); sn0.push_back(dn[0]); end
            if (pv[1] === 1'b1) sa1.push_back(pa[1]);
         end
      join_none
      repeat (3) cyc(1'b0, 1'b0, 32'd0);
      chk("reset_valid", pv[0], 0);
      chk("reset_data", pd[0], 0);
      chk("reset_addr", pa[0], 0);
      chk("reset_done", dn[1], 0);
      rst = 1'b0;
      repeat (3) cyc(1'b0, 1'b1, 32'd99);
      chk("idle_ignores_valid", pv[1], 0);
      // consecutive ramp
      b = sd0.size();
      cyc(1'b1, 1'b1, 32'h7fff_ffff);
      pixels(0, 1024, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 32'd0);
      ramp_check("ramp", b);
      chk("done_held", dn[0], 1);
      // gapped ramp, restarting from DONE
      b = sd0.size();
      cyc(1'b1, 1'b1, 32'h7fff_ffff);
      chk("restart_done_drop", dn[0], 0);
      pixels(0, 1024, 1'b1);
      repeat (4) cyc(1'b0, 1'b0, 32'd0);
      ramp_check("gap", b);
      // rotating max position
      b = sd0.size();
      cyc(1'b1, 1'b0, 32'd0);
      pixels(1, 1024, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 32'd0);
      chk("maxpos_count", sd0.size() - b, 256);
      for (int i = b; i < sd0.size(); i++) chk("maxpos_data", sd0[i], 500);
      // saturation windows
      b = sd0.size();
      cyc(1'b1, 1'b0, 32'd0);
      pixels(2, 1024, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 32'd0);
      chk("sat_count", sd0.size() - b, 256);
      if (sd0.size() - b == 256) begin
         chk("sat_pos_window", sd0[b], SAT_A);
         chk("sat_neg_window", sd0[b + 1], SAT_B);
         chk("sat_zero_window", sd0[b + 2], 0);
      end
      // mid-frame reset
      cyc(1'b1, 1'b0, 32'd0);
      pixels(3, 700, 1'b0);
      rst = 1'b1;
      repeat (2) cyc(1'b0, 1'b1, 32'd5);
      chk("mid_reset_valid", pv[1], 0);
      chk("mid_reset_data", pd[1], 0);
      chk("mid_reset_done", dn[0], 0);
      rst = 1'b0;
      repeat (3) cyc(1'b0, 1'b1, 32'd5);
      b1 = sa1.size();
      cyc(1'b1, 1'b1, 32'h7fff_ffff);
      pixels(3, 16384, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 32'd0);
      chk("full_count", sa1.size() - b1, 4096);
      if (sa1.size() - b1 == 4096) begin
         chk("full_first_addr", sa1[b1], 0);
         chk("full_last_addr", sa1[b1 + 4095], 4095);
      end
      chk("full_done", dn[1], 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
